// File: rtl/ex_stage.sv
// MIPS execute stage: operand forwarding, ALU, branch resolution and the
// EX/MEM pipeline register with stall (hold) and flush (bubble) control.
module ex_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [3:0]  alu_control,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   input  logic [31:0] imm,
   input  logic        alu_src,
   input  logic [1:0]  rs_fwd,
   input  logic [1:0]  rt_fwd,
   input  logic [31:0] wb_data,
   input  logic        reg_write_in,
   input  logic        mem_read_in,
   input  logic        mem_write_in,
   input  logic        branch_in,
   input  logic [4:0]  dest_reg_in,
   input  logic [31:0] pc_plus4_in,
   input  logic        stall,
   input  logic        flush,
   output logic        ex_valid,
   output logic [31:0] ex_result,
   output logic [31:0] ex_store_data,
   output logic [4:0]  ex_dest_reg,
   output logic        ex_reg_write,
   output logic        ex_mem_read,
   output logic        ex_mem_write,
   output logic        ex_zero,
   output logic        ex_branch_taken,
   output logic [31:0] ex_branch_target
);

   typedef struct packed {
      logic        valid;
      logic [31:0] result;
      logic [31:0] store_data;
      logic [4:0]  dest_reg;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        zero;
      logic        branch_taken;
      logic [31:0] branch_target;
   } exmem_t;

   exmem_t      exmem_q, exmem_d;
   logic [31:0] op_a, fwd_rt, op_b, alu_res;

   // EX/MEM forwarding reads the registered result even for loads; the
   // hazard unit guarantees a stall covers the load-use case.
   always_comb begin
      case (rs_fwd)
         2'b10:   op_a = exmem_q.result;
         2'b01:   op_a = wb_data;
         default: op_a = rs_data;
      endcase
      case (rt_fwd)
         2'b10:   fwd_rt = exmem_q.result;
         2'b01:   fwd_rt = wb_data;
         default: fwd_rt = rt_data;
      endcase
      op_b = alu_src ? imm : fwd_rt;
   end

   always_comb begin
      case (alu_control)
         4'b0010: alu_res = op_a + op_b;
         4'b0110: alu_res = op_a - op_b;
         4'b0001: alu_res = op_a | op_b;
         4'b0000: alu_res = op_a & op_b;
         4'b0111: alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
         default: alu_res = 32'd0;
      endcase
   end

   always_comb begin
      exmem_d               = '0;
      exmem_d.valid         = in_valid;
      exmem_d.result        = alu_res;
      exmem_d.store_data    = fwd_rt;
      exmem_d.dest_reg      = dest_reg_in;
      exmem_d.reg_write     = in_valid & reg_write_in;
      exmem_d.mem_read      = in_valid & mem_read_in;
      exmem_d.mem_write     = in_valid & mem_write_in;
      exmem_d.zero          = (alu_res == 32'd0);
      exmem_d.branch_taken  = in_valid & branch_in & (alu_res == 32'd0);
      exmem_d.branch_target = pc_plus4_in + {imm[29:0], 2'b00};
   end

   // Flush outranks stall so a squashed slot never survives a hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      exmem_q <= '0;
      else if (flush)  exmem_q <= '0;
      else if (!stall) exmem_q <= exmem_d;
   end

   assign ex_valid         = exmem_q.valid;
   assign ex_result        = exmem_q.result;
   assign ex_store_data    = exmem_q.store_data;
   assign ex_dest_reg      = exmem_q.dest_reg;
   assign ex_reg_write     = exmem_q.reg_write;
   assign ex_mem_read      = exmem_q.mem_read;
   assign ex_mem_write     = exmem_q.mem_write;
   assign ex_zero          = exmem_q.zero;
   assign ex_branch_taken  = exmem_q.branch_taken;
   assign ex_branch_target = exmem_q.branch_target;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU ops, forwarding, branch, stall/flush,
// bubble gating and asynchronous reset.
module tb_ex_stage;

   logic        clk, rst_n, in_valid, alu_src;
   logic [3:0]  alu_control;
   logic [31:0] rs_data, rt_data, imm, wb_data, pc_plus4_in;
   logic [1:0]  rs_fwd, rt_fwd;
   logic        reg_write_in, mem_read_in, mem_write_in, branch_in;
   logic [4:0]  dest_reg_in;
   logic        stall, flush;
   logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_zero, ex_branch_taken;
   logic [31:0] ex_result, ex_store_data, ex_branch_target;
   logic [4:0]  ex_dest_reg;

   int n_assert = 0;
   int n_fail   = 0;

   ex_stage dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .alu_control(alu_control),
      .rs_data(rs_data), .rt_data(rt_data), .imm(imm), .alu_src(alu_src),
      .rs_fwd(rs_fwd), .rt_fwd(rt_fwd), .wb_data(wb_data),
      .reg_write_in(reg_write_in), .mem_read_in(mem_read_in),
      .mem_write_in(mem_write_in), .branch_in(branch_in),
      .dest_reg_in(dest_reg_in), .pc_plus4_in(pc_plus4_in),
      .stall(stall), .flush(flush),
      .ex_valid(ex_valid), .ex_result(ex_result), .ex_store_data(ex_store_data),
      .ex_dest_reg(ex_dest_reg), .ex_reg_write(ex_reg_write),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_zero(ex_zero),
      .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".valid"},  {31'd0, ex_valid}, 0);
      chk({tag, ".result"}, ex_result, 0);
      chk({tag, ".store"},  ex_store_data, 0);
      chk({tag, ".dest"},   {27'd0, ex_dest_reg}, 0);
      chk({tag, ".ctrl"},   {28'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch_taken}, 0);
      chk({tag, ".zero"},   {31'd0, ex_zero}, 0);
      chk({tag, ".target"}, ex_branch_target, 0);
   endtask

   initial begin
      logic [3:0]  codes [5];
      logic [31:0] exps  [5];
      codes = '{4'b0010, 4'b0110, 4'b0001, 4'b0000, 4'b0111};
      exps  = '{32'd12, 32'd2, 32'd7, 32'd5, 32'd0};

      rst_n = 1'b0; in_valid = 0; alu_control = 0; rs_data = 0; rt_data = 0;
      imm = 0; alu_src = 0; rs_fwd = 0; rt_fwd = 0; wb_data = 0;
      reg_write_in = 0; mem_read_in = 0; mem_write_in = 0; branch_in = 0;
      dest_reg_in = 0; pc_plus4_in = 0; stall = 0; flush = 0;
      #12 rst_n = 1'b1;
      #1 chk_all_zero("reset");
      step();
      chk("idle_valid", {31'd0, ex_valid}, 0);

      // ALU ops with rs=7, rt=5
      in_valid = 1; reg_write_in = 1; rs_data = 7; rt_data = 5; dest_reg_in = 5'd3;
      for (int i = 0; i < 5; i++) begin
         alu_control = codes[i];
         step();
         chk($sformatf("alu_%b", codes[i]), ex_result, exps[i]);
      end
      chk("alu_valid", {31'd0, ex_valid}, 1);
      chk("alu_rw",    {31'd0, ex_reg_write}, 1);
      chk("alu_dest",  {27'd0, ex_dest_reg}, 3);

      alu_control = 4'b1111;
      step();
      chk("alu_undef", ex_result, 0);
      chk("alu_undef_zero", {31'd0, ex_zero}, 1);

      alu_control = 4'b0111; rs_data = 32'hFFFF_FFFF; rt_data = 1;
      step();
      chk("slt_signed", ex_result, 1);

      alu_control = 4'b0010;
      step();
      chk("add_wrap", ex_result, 0);
      chk("add_wrap_zero", {31'd0, ex_zero}, 1);

      // Async reset between edges
      rs_data = 2; rt_data = 2;
      step();
      chk("pre_reset_result", ex_result, 4);
      #2 rst_n = 1'b0;
      #1 chk_all_zero("async_reset");
      rst_n = 1'b1;

      // Forwarding
      rs_data = 3; rt_data = 4; alu_control = 4'b0010;
      step();
      chk("fwd_base", ex_result, 7);
      rs_fwd = 2'b10; rs_data = 32'd100; rt_data = 1;
      step();
      chk("fwd_exmem", ex_result, 8);
      rs_fwd = 2'b00; rs_data = 32'h20; rt_fwd = 2'b01; wb_data = 32'h100;
      rt_data = 32'hDEAD; alu_src = 1; imm = 4;
      step();
      chk("fwd_wb_result", ex_result, 32'h24);
      chk("fwd_wb_store",  ex_store_data, 32'h100);
      rs_fwd = 2'b11; rt_fwd = 2'b11; alu_src = 0; rs_data = 5; rt_data = 6;
      step();
      chk("fwd_11", ex_result, 11);

      // Branch
      rs_fwd = 0; rt_fwd = 0; alu_control = 4'b0110; rs_data = 9; rt_data = 9;
      branch_in = 1; pc_plus4_in = 32'h40; imm = 32'hFFFF_FFFE;
      step();
      chk("br_taken",  {31'd0, ex_branch_taken}, 1);
      chk("br_target", ex_branch_target, 32'h38);
      rt_data = 8;
      step();
      chk("br_not_taken", {31'd0, ex_branch_taken}, 0);
      chk("br_nt_result", ex_result, 1);

      // Stall and flush
      branch_in = 0; alu_control = 4'b0010; rs_data = 2; rt_data = 3;
      dest_reg_in = 5'd7; mem_write_in = 1;
      step();
      chk("stall_load", ex_result, 5);
      stall = 1; rs_data = 50; rt_data = 60; dest_reg_in = 5'd9; mem_write_in = 0;
      step();
      step();
      chk("stall_result", ex_result, 5);
      chk("stall_dest",   {27'd0, ex_dest_reg}, 7);
      chk("stall_mw",     {31'd0, ex_mem_write}, 1);
      chk("stall_store",  ex_store_data, 3);
      flush = 1;
      step();
      chk_all_zero("flush_stall");
      flush = 0; stall = 0;

      // Bubble gating
      in_valid = 0; reg_write_in = 1; mem_write_in = 1; mem_read_in = 1; branch_in = 1;
      alu_control = 4'b0110; rs_data = 4; rt_data = 4;
      step();
      chk("bub_ctrl", {27'd0, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch_taken}, 0);
      chk("bub_zero", {31'd0, ex_zero}, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
